// File: rtl/video_timing_if.sv
// Raster timing output bundle plus the pixel-advance enable.
// The master is the timing generator; the slave is the pixel/pattern consumer.
interface video_timing_if #(
  parameter int CW = 10,
  parameter int FW = 8
);
  logic          i_en;
  logic          o_hsync;
  logic          o_vsync;
  logic          o_de;
  logic [CW-1:0] o_x;
  logic [CW-1:0] o_y;
  logic          o_sof;
  logic          o_eol;
  logic [FW-1:0] o_frame;

  modport master (
    input  i_en,
    output o_hsync, o_vsync, o_de, o_x, o_y, o_sof, o_eol, o_frame
  );
  modport slave (
    output i_en,
    input  o_hsync, o_vsync, o_de, o_x, o_y, o_sof, o_eol, o_frame
  );
endinterface

// File: rtl/video_timing.sv
// Single-domain raster timing generator: one h/v position counter with all
// outputs registered from the next position, so sync, DE and coordinates never skew.
module video_timing #(
  parameter int H_ACTIVE = 480,
  parameter int H_FP     = 8,
  parameter int H_SYNC   = 4,
  parameter int H_BP     = 43,
  parameter int V_ACTIVE = 272,
  parameter int V_FP     = 8,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 12,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CW       = 10,
  parameter int FW       = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  video_timing_if.master vt
);
  localparam int   H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int   V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic HS_ON   = 1'(HS_POL);
  localparam logic VS_ON   = 1'(VS_POL);

  if (H_TOTAL > (1 << CW)) begin : g_h_err
    $error("video_timing: H_TOTAL exceeds 2^CW");
  end
  if (V_TOTAL > (1 << CW)) begin : g_v_err
    $error("video_timing: V_TOTAL exceeds 2^CW");
  end

  logic [CW-1:0] h, v, h_nx, v_nx;
  logic          started;
  logic          de_nx, hs_nx, vs_nx, sof_nx, eol_nx;

  logic          hsync_q, vsync_q, de_q, sof_q, eol_q;
  logic [CW-1:0] x_q, y_q;
  logic [FW-1:0] frame_q;

  // Until the first enabled edge after reset, the next position is (0,0)
  // rather than an advance, so that edge presents the origin and counts a frame.
  always_comb begin
    h_nx = '0;
    v_nx = '0;
    if (started) begin
      if (int'(h) == H_TOTAL - 1) begin
        h_nx = '0;
        v_nx = (int'(v) == V_TOTAL - 1) ? '0 : v + 1'b1;
      end else begin
        h_nx = h + 1'b1;
        v_nx = v;
      end
    end
  end

  always_comb begin
    de_nx  = (int'(h_nx) < H_ACTIVE) && (int'(v_nx) < V_ACTIVE);
    hs_nx  = (int'(h_nx) >= H_ACTIVE + H_FP) && (int'(h_nx) < H_ACTIVE + H_FP + H_SYNC);
    vs_nx  = (int'(v_nx) >= V_ACTIVE + V_FP) && (int'(v_nx) < V_ACTIVE + V_FP + V_SYNC);
    sof_nx = (h_nx == '0) && (v_nx == '0);
    eol_nx = (int'(h_nx) == H_ACTIVE - 1) && (int'(v_nx) < V_ACTIVE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      started <= 1'b0;
      h       <= '0;
      v       <= '0;
      hsync_q <= ~HS_ON;
      vsync_q <= ~VS_ON;
      de_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      frame_q <= '0;
    end else if (vt.i_en) begin
      started <= 1'b1;
      h       <= h_nx;
      v       <= v_nx;
      hsync_q <= hs_nx ? HS_ON : ~HS_ON;
      vsync_q <= vs_nx ? VS_ON : ~VS_ON;
      de_q    <= de_nx;
      x_q     <= de_nx ? h_nx : '0;
      y_q     <= de_nx ? v_nx : '0;
      sof_q   <= sof_nx;
      eol_q   <= eol_nx;
      if (sof_nx) frame_q <= frame_q + 1'b1;
    end else begin
      // Strobes mark entry only; a held cycle is not a new entry.
      sof_q <= 1'b0;
      eol_q <= 1'b0;
    end
  end

  assign vt.o_hsync = hsync_q;
  assign vt.o_vsync = vsync_q;
  assign vt.o_de    = de_q;
  assign vt.o_x     = x_q;
  assign vt.o_y     = y_q;
  assign vt.o_sof   = sof_q;
  assign vt.o_eol   = eol_q;
  assign vt.o_frame = frame_q;
endmodule

// File: doc/video_timing.md
Name: video_timing

Overview:
- Parametrised raster timing generator for the RGB LCD path. It replaces the separate hsync and vsync counters with a single block running in one clock domain, rather than clocking the vertical counter from HSYNC.
- Produces HSYNC, VSYNC, DE, pixel coordinates, a start-of-frame strobe, an end-of-line strobe and a frame counter. Pattern and pixel logic then run on the pixel clock instead of using sync signals as clocks.
- Adds a pixel clock-enable so the block can run from a faster system clock.

Parameters:
- H_ACTIVE, 480, visible pixels per line
- H_FP, 8, horizontal front porch (clocks)
- H_SYNC, 4, HSYNC pulse width (clocks)
- H_BP, 43, horizontal back porch (clocks)
- V_ACTIVE, 272, visible lines per frame
- V_FP, 8, vertical front porch (lines)
- V_SYNC, 4, VSYNC pulse width (lines)
- V_BP, 12, vertical back porch (lines)
- HS_POL, 0, HSYNC active level (0 = active-low)
- VS_POL, 0, VSYNC active level
- CW, 10, coordinate and counter width
- FW, 8, frame counter width

Ports:
- i_clk  in  1  pixel/system clock
- i_rst  in  1  synchronous reset, active-high
- i_en  in  1  pixel advance enable (tie 1 for one pixel per clock)
- o_hsync  out  1  horizontal sync, polarity HS_POL
- o_vsync  out  1  vertical sync, polarity VS_POL
- o_de  out  1  data enable: active pixel
- o_x  out  CW  pixel column, 0 outside the active region
- o_y  out  CW  pixel row, 0 outside the active region
- o_sof  out  1  one-clock strobe on entry to pixel (0,0)
- o_eol  out  1  one-clock strobe on entry to the last active pixel of a line
- o_frame  out  FW  frame count, wraps modulo 2^FW

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (i_clk, i_rst).
- Totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
  - Elaboration error if H_TOTAL or V_TOTAL exceeds 2^CW.
- Position (h,v). Line order is active [0,H_ACTIVE), front porch, sync, back porch. Frame order is the same in lines.
- Advance rule:
  - At each edge with i_rst=0 and i_en=1, the position advances: h+1.
  - At h=H_TOTAL-1, h wraps to 0 and v advances.
  - At v=V_TOTAL-1 with h wrap, v wraps to 0.
  - With i_en=0, position and all level outputs hold.
- Reset: an edge with i_rst=1 gives o_hsync=!HS_POL, o_vsync=!VS_POL, o_de=0, o_x=0, o_y=0, o_sof=0, o_eol=0, o_frame=0.
- First presented pixel: the first edge with i_rst=0 and i_en=1 presents position (0,0). All outputs are registered and consistent with the presented position in the same cycle; there is no skew between sync, DE and coordinates.
- Output decode:
  - o_de = (h<H_ACTIVE)&&(v<V_ACTIVE).
  - o_x = h and o_y = v when o_de, else 0.
  - o_hsync active iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, on every line.
  - o_vsync active for all h of lines V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC.
- Strobes:
  - o_sof is high for exactly the one clock at which (0,0) is entered; it is low on held cycles (i_en=0).
  - o_frame increments at that same edge. The post-reset entry counts, so o_frame=1 during the first frame; wrap 2^FW-1 -> 0.
  - o_eol: same rule at entry of h=H_ACTIVE-1 on active lines only.
- Reset mid-frame: takes effect at the next edge regardless of i_en. Position restarts at (0,0) on the first enabled edge after release.

Test Plan:
- Reset defaults: with HS_POL=0 and VS_POL=0, hold i_rst 3 clocks -> o_hsync=1, o_vsync=1, o_de=0, x=y=0, o_frame=0, strobes 0.
- Small timing (H 4/1/2/1, V 3/1/1/1, i_en=1), giving 8x6=48 clocks per frame:
  - o_sof at clocks 0, 48, 96.
  - o_hsync low at h=5,6 of every line.
  - o_vsync low for the whole of line v=4.
  - 12 DE clocks per frame; x sequence 0..3 on rows 0..2.
  - o_eol at h=3 of rows 0..2 only.
- i_en toggling 1,0 repeatedly, same params -> frame takes 96 clocks. Outputs hold on i_en=0 cycles; o_sof high exactly 1 clock per frame.
- HS_POL=1, VS_POL=1 -> sync pulses high at the same positions; reset levels 0.
- FW=2, run 5 frames -> o_frame sequence 1,2,3,0,1.
- Assert i_rst at (2,1) for 1 clock -> next enabled edge after release shows o_sof=1, (0,0), o_frame=1.
